avalon_bus_mux: RTL and testbench

- Parametrised data-bus interconnect between the pipeline's memory stage and NUM_DEV memory-mapped devices (data memory, FP unit, I/O).
- Decodes the upper DEV_BITS of DataAddr to select a device and forwards read/write strobes to it.
- Inserts per-device programmable wait states and honours each device's own wait request.
- Returns read data and a Waitreq stall to the pipeline; flags decode errors, bad commands and timeouts.

---
 rtl/avalon_bus_mux.sv | 159 +++++++++++++++
 tb/tb_avalon_bus_mux.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_mux.sv
// Data-bus interconnect: decodes the upper address bits to one of NUM_DEV devices,
// inserts per-device wait states, honours device wait requests and flags errors/timeouts.
module avalon_bus_mux #(
    parameter int unsigned                   DATA_W      = 16,
    parameter int unsigned                   ADDR_W      = 16,
    parameter int unsigned                   DEV_BITS    = 4,
    parameter int unsigned                   NUM_DEV     = 4,
    parameter int unsigned                   LAT_W       = 4,
    parameter logic [NUM_DEV*LAT_W-1:0]      DEV_LATENCY = 16'h0210,
    parameter int unsigned                   TIMEOUT     = 64
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         ReadData,
    input  logic                         WriteData,
    input  logic [ADDR_W-1:0]            DataAddr,
    input  logic [DATA_W-1:0]            BusIn,
    output logic [DATA_W-1:0]            BusOut,
    output logic                         Waitreq,
    output logic                         BusError,
    output logic [ADDR_W-DEV_BITS-1:0]   DevAddr,
    output logic [DATA_W-1:0]            DevWData,
    output logic [NUM_DEV-1:0]           DevRead,
    output logic [NUM_DEV-1:0]           DevWrite,
    input  logic [NUM_DEV*DATA_W-1:0]    DevRData,
    input  logic [NUM_DEV-1:0]           DevWaitreq
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_q, state_d;
    logic [DEV_BITS-1:0]  dev_q, dev_d;
    logic                 rd_q, rd_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic [DEV_BITS-1:0]  addr_dev, sel_dev;
    logic [DATA_W-1:0]    sel_rdata;
    logic [LAT_W-1:0]     sel_lat, cnt_dec;
    logic                 sel_wait, mapped;
    logic [NUM_DEV-1:0]   sel_onehot;
    logic                 req, idle_err, idle_fast, abort, done, timeout;

    assign addr_dev = DataAddr[ADDR_W-1 -: DEV_BITS];
    assign sel_dev  = (state_q == WAIT) ? dev_q : addr_dev;
    assign DevAddr  = DataAddr[ADDR_W-DEV_BITS-1:0];
    assign DevWData = BusIn;

    // Device lookup; indices beyond NUM_DEV match nothing, which makes them unmapped.
    always_comb begin
        sel_rdata  = '0;
        sel_lat    = '0;
        sel_wait   = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (sel_dev == DEV_BITS'(i)) begin
                sel_rdata     = DevRData[i*DATA_W +: DATA_W];
                sel_lat       = DEV_LATENCY[i*LAT_W +: LAT_W];
                sel_wait      = DevWaitreq[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign mapped = |sel_onehot;

    // The decrement is applied within the current WAIT cycle, so the accept cycle counts as one wait state.
    always_comb begin
        cnt_dec   = (cnt_q != '0) ? cnt_q - LAT_W'(1) : '0;
        req       = ReadData | WriteData;
        idle_err  = req & ((ReadData & WriteData) | ~mapped);
        idle_fast = req & ~idle_err & (sel_lat == '0) & ~sel_wait;
        abort     = rd_q ? ~ReadData : ~WriteData;
        done      = ~abort & (cnt_dec == '0) & ~sel_wait;
        timeout   = ~abort & ~done & (tmo_q == TMO_W'(TIMEOUT));
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            dev_q   <= '0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dev_d   = dev_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (req && !idle_err && !idle_fast) begin
                    state_d = WAIT;
                    dev_d   = addr_dev;
                    rd_d    = ReadData;
                    cnt_d   = sel_lat;
                    tmo_d   = TMO_W'(1);
                end
            end
            WAIT: begin
                cnt_d = cnt_dec;
                tmo_d = tmo_q + TMO_W'(1);
                if (abort || done || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BusOut   = '0;
        Waitreq  = 1'b0;
        BusError = 1'b0;
        DevRead  = '0;
        DevWrite = '0;
        if (Resetn) begin
            case (state_q)
                IDLE: begin
                    BusError = idle_err;
                    if (req && !idle_err) begin
                        DevRead  = ReadData  ? sel_onehot : '0;
                        DevWrite = WriteData ? sel_onehot : '0;
                        Waitreq  = ~idle_fast;
                        if (idle_fast && ReadData) begin
                            BusOut = sel_rdata;
                        end
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        BusError = 1'b1;
                    end else if (!abort) begin
                        DevRead  = rd_q  ? sel_onehot : '0;
                        DevWrite = !rd_q ? sel_onehot : '0;
                        Waitreq  = ~done;
                        if (done && rd_q) begin
                            BusOut = sel_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_bus_mux.sv
// Bench for avalon_bus_mux: directed transactions, a per-cycle transaction-age model
// and literal expectations for each scenario.
module tb_avalon_bus_mux;

    localparam int TIMEOUT = 64;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         ReadData, WriteData;
    logic [15:0]  DataAddr, BusIn;
    logic [15:0]  BusOut;
    logic         Waitreq, BusError;
    logic [11:0]  DevAddr;
    logic [15:0]  DevWData;
    logic [3:0]   DevRead, DevWrite;
    logic [63:0]  DevRData;
    logic [3:0]   DevWaitreq;

    logic [15:0]  rdv [4];
    int           lat [4];

    int checks = 0;
    int errors = 0;

    assign DevRData = {rdv[3], rdv[2], rdv[1], rdv[0]};

    always #5 Clock = ~Clock;

    avalon_bus_mux #(
        .DATA_W(16), .ADDR_W(16), .DEV_BITS(4), .NUM_DEV(4), .LAT_W(4),
        .DEV_LATENCY(16'h0210), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .ReadData(ReadData), .WriteData(WriteData),
        .DataAddr(DataAddr), .BusIn(BusIn), .BusOut(BusOut), .Waitreq(Waitreq),
        .BusError(BusError), .DevAddr(DevAddr), .DevWData(DevWData),
        .DevRead(DevRead), .DevWrite(DevWrite), .DevRData(DevRData), .DevWaitreq(DevWaitreq)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: a transaction is tracked by its age in cycles since acceptance.
    bit          m_busy = 0;
    int          m_dev, m_L, m_age;
    bit          m_rd;

    always @(negedge Clock) begin
        logic [15:0] e_out;
        logic        e_wait, e_err;
        logic [3:0]  e_rd, e_wr;
        int          d;
        e_out = '0; e_wait = 0; e_err = 0; e_rd = '0; e_wr = '0;
        if (!Resetn) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (ReadData || WriteData) begin
                d = int'(DataAddr[15:12]);
                if ((ReadData && WriteData) || d >= 4) begin
                    e_err = 1;
                end else begin
                    if (ReadData) e_rd[d] = 1'b1; else e_wr[d] = 1'b1;
                    if (lat[d] == 0 && !DevWaitreq[d]) begin
                        if (ReadData) e_out = rdv[d];
                    end else begin
                        e_wait = 1; m_busy = 1; m_dev = d; m_rd = ReadData; m_L = lat[d]; m_age = 1;
                    end
                end
            end
        end else begin
            if (m_rd ? !ReadData : !WriteData) begin
                m_busy = 0;
            end else if (m_age >= m_L && !DevWaitreq[m_dev]) begin
                if (m_rd) begin e_rd[m_dev] = 1'b1; e_out = rdv[m_dev]; end
                else e_wr[m_dev] = 1'b1;
                m_busy = 0;
            end else if (m_age == TIMEOUT) begin
                e_err = 1; m_busy = 0;
            end else begin
                if (m_rd) e_rd[m_dev] = 1'b1; else e_wr[m_dev] = 1'b1;
                e_wait = 1; m_age++;
            end
        end
        cmp("m_Waitreq", 32'(Waitreq), 32'(e_wait));
        cmp("m_BusError", 32'(BusError), 32'(e_err));
        cmp("m_BusOut", 32'(BusOut), 32'(e_out));
        cmp("m_DevRead", 32'(DevRead), 32'(e_rd));
        cmp("m_DevWrite", 32'(DevWrite), 32'(e_wr));
        cmp("m_DevAddr", 32'(DevAddr), 32'(DataAddr[11:0]));
        cmp("m_DevWData", 32'(DevWData), 32'(BusIn));
    end

    // Holds the request until Waitreq drops at a sample point; strobes stay high on return.
    task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] dat,
                       input logic [3:0] dwmask, input int dw_hold,
                       output int hi, output logic [15:0] bout, output logic berr,
                       output logic [3:0] srd, output logic [3:0] swr);
        bit fin;
        hi = 0; fin = 0; bout = '0; berr = 0; srd = '0; swr = '0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(posedge Clock); #1;
            if (i == 0) begin ReadData = rd; WriteData = wr; DataAddr = a; BusIn = dat; end
            DevWaitreq = (i < dw_hold) ? dwmask : 4'b0000;
            @(negedge Clock);
            if (i == 0) begin srd = DevRead; swr = DevWrite; end
            if (Waitreq) hi++;
            else begin fin = 1; bout = BusOut; berr = BusError; end
        end
        if (!fin) cmp("txn_budget", 32'(fin), 32'(1));
    endtask

    task automatic idle();
        @(posedge Clock); #1;
        ReadData = 0; WriteData = 0; DevWaitreq = '0;
    endtask

    initial begin
        int          hi;
        logic [15:0] bo;
        logic        be;
        logic [3:0]  sr, sw;

        rdv[0] = 16'hBEEF; rdv[1] = 16'h1111; rdv[2] = 16'h2222; rdv[3] = 16'h3333;
        lat[0] = 0; lat[1] = 1; lat[2] = 2; lat[3] = 0;
        Resetn = 0; ReadData = 0; WriteData = 0; DataAddr = '0; BusIn = '0; DevWaitreq = '0;

        @(negedge Clock);
        cmp("rst_Waitreq", 32'(Waitreq), 32'(0));
        cmp("rst_BusOut", 32'(BusOut), 32'(0));
        cmp("rst_DevRead", 32'(DevRead), 32'(0));
        cmp("rst_BusError", 32'(BusError), 32'(0));
        @(posedge Clock); #1; Resetn = 1;

        txn(1, 0, 16'h0123, 16'h0000, 4'b0000, 0, hi, bo, be, sr, sw);
        cmp("rd0_hi", 32'(hi), 32'(0));
        cmp("rd0_BusOut", 32'(bo), 32'hBEEF);
        cmp("rd0_DevRead", 32'(sr), 32'(4'b0001));
        cmp("rd0_DevAddr", 32'(DevAddr), 32'h123);
        idle();

        txn(0, 1, 16'h2040, 16'h55AA, 4'b0000, 0, hi, bo, be, sr, sw);
        cmp("wr2_hi", 32'(hi), 32'(2));
        cmp("wr2_DevWrite", 32'(sw), 32'(4'b0100));
        cmp("wr2_BusOut", 32'(bo), 32'(0));
        idle();

        txn(1, 0, 16'h1008, 16'h0000, 4'b0010, 4, hi, bo, be, sr, sw);
        cmp("rd1_hi", 32'(hi), 32'(4));
        cmp("rd1_BusOut", 32'(bo), 32'h1111);
        idle();

        txn(1, 0, 16'h7000, 16'h0000, 4'b0000, 0, hi, bo, be, sr, sw);
        cmp("unmap_hi", 32'(hi), 32'(0));
        cmp("unmap_err", 32'(be), 32'(1));
        cmp("unmap_DevRead", 32'(sr), 32'(0));
        idle();

        txn(1, 1, 16'h0000, 16'h1234, 4'b0000, 0, hi, bo, be, sr, sw);
        cmp("dual_err", 32'(be), 32'(1));
        cmp("dual_strobes", 32'({sr, sw}), 32'(0));
        idle();

        // Back-to-back: dev0 read then dev1 write with no idle cycle between.
        txn(1, 0, 16'h0010, 16'h0000, 4'b0000, 0, hi, bo, be, sr, sw);
        cmp("b2b_rd_BusOut", 32'(bo), 32'hBEEF);
        txn(0, 1, 16'h1004, 16'hA5A5, 4'b0000, 0, hi, bo, be, sr, sw);
        cmp("b2b_wr_hi", 32'(hi), 32'(1));
        idle();

        txn(1, 0, 16'h3000, 16'h0000, 4'b1000, 1000, hi, bo, be, sr, sw);
        cmp("tmo_hi", 32'(hi), 32'(TIMEOUT));
        cmp("tmo_err", 32'(be), 32'(1));
        cmp("tmo_BusOut", 32'(bo), 32'(0));
        idle();

        // Master abort during a dev2 read.
        @(posedge Clock); #1; ReadData = 1; DataAddr = 16'h2001;
        @(negedge Clock); cmp("abort_w0", 32'(Waitreq), 32'(1));
        @(posedge Clock); #1; ReadData = 0;
        @(negedge Clock);
        cmp("abort_Waitreq", 32'(Waitreq), 32'(0));
        cmp("abort_DevRead", 32'(DevRead), 32'(0));
        cmp("abort_err", 32'(BusError), 32'(0));

        // Reset pulsed during a dev2 write WAIT.
        @(posedge Clock); #1; WriteData = 1; DataAddr = 16'h2040; BusIn = 16'h55AA;
        @(negedge Clock);
        @(posedge Clock); #1;
        @(negedge Clock); cmp("rstw_pre_Waitreq", 32'(Waitreq), 32'(1));
        @(posedge Clock); #1; Resetn = 0;
        @(negedge Clock);
        cmp("rstw_Waitreq", 32'(Waitreq), 32'(0));
        cmp("rstw_DevWrite", 32'(DevWrite), 32'(0));
        @(posedge Clock); #1; Resetn = 1; WriteData = 0;

        txn(1, 0, 16'h0123, 16'h0000, 4'b0000, 0, hi, bo, be, sr, sw);
        cmp("post_rst_hi", 32'(hi), 32'(0));
        cmp("post_rst_BusOut", 32'(bo), 32'hBEEF);
        idle();
        @(negedge Clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
